dm_result_checker: RTL and testbench

// - Synthesizable, parametrised successor of the top-level simulation checker; sits beside the CPU top.
// - Snoops DM writes for the end-of-program marker, then walks the result region over a DM read port.
// - Compares each result word against a golden ROM; keeps a cycle counter and NUM_EVT event counters
//   (branch count, branch-hit count, ...).

---
 rtl/chk_pkg.sv | 26 ++
 rtl/dm_result_checker_if.sv | 31 +++
 rtl/evt_counter_bank.sv | 38 +++
 rtl/dm_result_checker.sv | 151 +++++++++++++++
 tb/tb_dm_result_checker.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chk_pkg.sv
// Shared types, default constants and helpers for the DM result checker.
package chk_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      CHECK_REQ  = 2'd1,
      CHECK_WAIT = 2'd2,
      DONE       = 2'd3
   } chk_state_e;

   localparam int unsigned DEF_END_ADDR   = 'h3fff;
   localparam int unsigned DEF_TEST_START = 'h2000;
   localparam logic [31:0] DEF_END_CODE   = 32'hFFFF_FFFF;

   // Widest counter the saturating helper supports.
   localparam int unsigned CNT_MAX_W = 64;

   // Increment v, holding at all-ones of a w-bit counter (w <= CNT_MAX_W).
   function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v,
                                                    input int unsigned          w);
      logic [CNT_MAX_W-1:0] ones;
      ones = (w >= CNT_MAX_W) ? '1 : ((CNT_MAX_W'(1) << w) - CNT_MAX_W'(1));
      return (v == ones) ? v : v + CNT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/dm_result_checker_if.sv
// DM snoop, DM read port and golden ROM port seen by the result checker.
interface dm_result_checker_if #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 32,
   parameter int GOLD_AW = 6
);
   // DM write snoop
   logic              dm_we;
   logic [ADDR_W-1:0] dm_waddr;
   logic [DATA_W-1:0] dm_wdata;
   // DM read port
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [DATA_W-1:0] rd_data;
   // Golden ROM (synchronous, 1-cycle latency)
   logic [GOLD_AW-1:0] gold_addr;
   logic [DATA_W-1:0]  gold_data;

   // Checker side
   modport master (
      input  dm_we, dm_waddr, dm_wdata, rd_ack, rd_data, gold_data,
      output rd_req, rd_addr, gold_addr
   );

   // Memory / CPU side
   modport slave (
      output dm_we, dm_waddr, dm_wdata, rd_ack, rd_data, gold_data,
      input  rd_req, rd_addr, gold_addr
   );
endinterface

// File: rtl/evt_counter_bank.sv
// Bank of saturating event counters that stop counting while freeze is high.
module evt_counter_bank
   import chk_pkg::*;
#(
   parameter int NUM_EVT = 2,
   parameter int CNT_W   = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     freeze,
   input  logic [NUM_EVT-1:0]       evt_inc,
   output logic [NUM_EVT*CNT_W-1:0] evt_cnt
);

   logic [NUM_EVT*CNT_W-1:0] cnt_q, cnt_d;

   // Per-channel saturating increment on each pulse unless frozen.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      for (int k = 0; k < NUM_EVT; k++) begin
         if (!freeze && evt_inc[k]) begin
            cnt_d[k*CNT_W +: CNT_W] =
               CNT_W'(sat_inc(CNT_MAX_W'(cnt_q[k*CNT_W +: CNT_W]), CNT_W));
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign evt_cnt = cnt_q;

endmodule

// File: rtl/dm_result_checker.sv
// Waits for the end-of-program marker (or a timeout), then reads the result
// region from DM and compares it word by word against a golden ROM.
module dm_result_checker
   import chk_pkg::*;
#(
   parameter int              ADDR_W     = 14,
   parameter int              DATA_W     = 32,
   parameter int unsigned     END_ADDR   = DEF_END_ADDR,
   parameter logic [DATA_W-1:0] END_CODE = DATA_W'(DEF_END_CODE),
   parameter int unsigned     TEST_START = DEF_TEST_START,
   parameter int              MAX_WORDS  = 64,
   parameter int              NUM_EVT    = 2,
   parameter int              CNT_W      = 64,
   parameter int unsigned     TIMEOUT    = 100000,
   localparam int             NW_W       = $clog2(MAX_WORDS + 1),
   localparam int             GOLD_AW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   dm_result_checker_if.master      bus,
   input  logic [NW_W-1:0]          num_words,
   input  logic [NUM_EVT-1:0]       evt_inc,
   output logic                     done,
   output logic                     pass,
   output logic                     timeout,
   output logic [NW_W-1:0]          err_cnt,
   output logic [ADDR_W-1:0]        first_err_addr,
   output logic [DATA_W-1:0]        first_err_data,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [NUM_EVT*CNT_W-1:0] evt_cnt
);

   chk_state_e         state_q, state_d;
   logic [GOLD_AW-1:0] idx_q, idx_d;
   logic [NW_W-1:0]    n_q, n_d;
   logic [NW_W-1:0]    err_q, err_d;
   logic [ADDR_W-1:0]  ferr_addr_q, ferr_addr_d;
   logic [DATA_W-1:0]  ferr_data_q, ferr_data_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   cycle_q, cycle_d;
   logic               freeze;
   logic               marker;
   logic               tmo_hit;
   logic [ADDR_W-1:0]  rd_addr_w;

   assign marker  = bus.dm_we && (bus.dm_waddr == ADDR_W'(END_ADDR)) && (bus.dm_wdata == END_CODE);
   assign tmo_hit = (cycle_q == CNT_W'(TIMEOUT - 1));

   // Result address wraps naturally in ADDR_W bits.
   assign rd_addr_w = ADDR_W'(TEST_START) + ADDR_W'(idx_q);

   // Next-state, index, comparator and error-capture logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      n_d         = n_q;
      err_d       = err_q;
      ferr_addr_d = ferr_addr_q;
      ferr_data_d = ferr_data_q;
      timeout_d   = timeout_q;
      cycle_d     = cycle_q;
      freeze      = 1'b1;

      unique case (state_q)
         RUN: begin
            if (marker || tmo_hit) begin
               // Marker wins over a simultaneous timeout.
               timeout_d = !marker;
               idx_d     = '0;
               n_d       = (num_words > NW_W'(MAX_WORDS)) ? NW_W'(MAX_WORDS) : num_words;
               state_d   = (n_d == '0) ? DONE : CHECK_REQ;
            end else begin
               freeze  = 1'b0;
               cycle_d = CNT_W'(sat_inc(CNT_MAX_W'(cycle_q), CNT_W));
            end
         end

         CHECK_REQ: state_d = CHECK_WAIT;

         CHECK_WAIT: begin
            if (bus.rd_ack) begin
               if (bus.rd_data != bus.gold_data) begin
                  err_d = err_q + NW_W'(1);
                  if (err_q == '0) begin
                     ferr_addr_d = rd_addr_w;
                     ferr_data_d = bus.rd_data;
                  end
               end
               if (NW_W'(idx_q) == n_q - NW_W'(1)) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + GOLD_AW'(1);
                  state_d = CHECK_REQ;
               end
            end
         end

         DONE: ;

         default: state_d = RUN;
      endcase
   end

   // Checker state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         idx_q       <= '0;
         n_q         <= '0;
         err_q       <= '0;
         ferr_addr_q <= '0;
         ferr_data_q <= '0;
         timeout_q   <= 1'b0;
         cycle_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         n_q         <= n_d;
         err_q       <= err_d;
         ferr_addr_q <= ferr_addr_d;
         ferr_data_q <= ferr_data_d;
         timeout_q   <= timeout_d;
         cycle_q     <= cycle_d;
      end
   end

   evt_counter_bank #(
      .NUM_EVT (NUM_EVT),
      .CNT_W   (CNT_W)
   ) u_evt (
      .clk     (clk),
      .rst     (rst),
      .freeze  (freeze),
      .evt_inc (evt_inc),
      .evt_cnt (evt_cnt)
   );

   // rd_req is decoded from the state flop, so it drops as soon as reset clears the state.
   assign bus.rd_req    = (state_q == CHECK_REQ) || (state_q == CHECK_WAIT);
   assign bus.rd_addr   = rd_addr_w;
   assign bus.gold_addr = idx_q;

   assign done           = (state_q == DONE);
   assign pass           = done && (err_q == '0) && !timeout_q;
   assign timeout        = timeout_q;
   assign err_cnt        = err_q;
   assign first_err_addr = ferr_addr_q;
   assign first_err_data = ferr_data_q;
   assign cycle_cnt      = cycle_q;

endmodule

// File: tb/tb_dm_result_checker.sv
// Directed bench for dm_result_checker: table of full-run scenarios plus
// hand-written sequences for event counting and reset during a read wait.
module tb_dm_result_checker;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 32;
   localparam int MAX_WORDS = 64;
   localparam int NUM_EVT   = 2;
   localparam int CNT_W     = 64;
   localparam int TIMEOUT   = 300;
   localparam int NW_W      = 7;
   localparam int GOLD_AW   = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NW_W-1:0]          num_words;
   logic [NUM_EVT-1:0]       evt_inc;
   logic                     done, pass, timeout;
   logic [NW_W-1:0]          err_cnt;
   logic [ADDR_W-1:0]        first_err_addr;
   logic [DATA_W-1:0]        first_err_data;
   logic [CNT_W-1:0]         cycle_cnt;
   logic [NUM_EVT*CNT_W-1:0] evt_cnt;

   dm_result_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GOLD_AW(GOLD_AW)) bus ();

   dm_result_checker #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_WORDS (MAX_WORDS),
      .NUM_EVT   (NUM_EVT),
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .num_words      (num_words),
      .evt_inc        (evt_inc),
      .done           (done),
      .pass           (pass),
      .timeout        (timeout),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data),
      .cycle_cnt      (cycle_cnt),
      .evt_cnt        (evt_cnt)
   );

   // Memory models
   logic [31:0] gold_mem [MAX_WORDS];
   logic [31:0] dm_mem   [16384];
   int          ack_delay;
   int          wait_cnt;

   always @(posedge clk) bus.gold_data <= gold_mem[bus.gold_addr];

   // DM read responder: acks ack_delay+1 cycles after rd_req rises.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rd_ack  <= 1'b0;
         bus.rd_data <= '0;
         wait_cnt    <= 0;
      end else begin
         bus.rd_ack <= 1'b0;
         if (bus.rd_req && !bus.rd_ack) begin
            if (wait_cnt >= ack_delay) begin
               bus.rd_ack  <= 1'b1;
               bus.rd_data <= dm_mem[bus.rd_addr];
               wait_cnt    <= 0;
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end else begin
            wait_cnt <= 0;
         end
      end
   end

   // Handshake log
   int               hs_cnt;
   logic [ADDR_W-1:0] hs_addr [MAX_WORDS];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs_cnt <= 0;
      end else if (bus.rd_req && bus.rd_ack) begin
         if (hs_cnt < MAX_WORDS) hs_addr[hs_cnt] <= bus.rd_addr;
         hs_cnt <= hs_cnt + 1;
      end
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
      else             n_pass++;
   endtask

   function automatic logic [31:0] gold_val(input int i);
      return (i == 2) ? 32'h0000_BEEF : 32'h1000_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   // Reset, load memories (masked words corrupted), release reset at a negedge.
   task automatic start_run(input int num, input int delay, input logic [63:0] mask);
      bus.dm_we    = 1'b0;
      bus.dm_waddr = '0;
      bus.dm_wdata = '0;
      evt_inc      = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < MAX_WORDS; i++) begin
         gold_mem[i] = gold_val(i);
         if (mask[i]) dm_mem[14'h2000 + i] = (i == 2) ? 32'h0000_DEAD : ~gold_val(i);
         else         dm_mem[14'h2000 + i] = gold_val(i);
      end
      num_words = NW_W'(num);
      ack_delay = delay;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Drive a DM write for one cycle at the current negedge.
   task automatic dm_write(input logic [13:0] a, input logic [31:0] d);
      bus.dm_we    = 1'b1;
      bus.dm_waddr = a;
      bus.dm_wdata = d;
   endtask

   task automatic wait_done(input int max_cycles);
      int n = 0;
      while (!done && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", done, 1'b1);
   endtask

   typedef struct {
      string       name;
      int          num;
      int          marker;     // cycle of the END_CODE write, 0 = none
      int          junk;       // cycle of a non-marker write to END_ADDR, 0 = none
      logic [63:0] mask;
      int          delay;
      logic [63:0] exp_cycle;
      int          exp_err;
      logic [13:0] exp_faddr;
      logic [31:0] exp_fdata;
      bit          exp_pass;
      bit          exp_tmo;
      int          exp_hs;
   } vec_t;

   vec_t vecs [7];

   initial begin
      rst = 1'b1;
      bus.dm_we = 1'b0;
      bus.dm_waddr = '0;
      bus.dm_wdata = '0;
      num_words = '0;
      evt_inc = '0;
      ack_delay = 0;
      #1 rst = 1'b0;
      #1;
      check("rst.done",    done, 1'b0);
      check("rst.pass",    pass, 1'b0);
      check("rst.timeout", timeout, 1'b0);
      check("rst.err_cnt", err_cnt, 0);
      check("rst.rd_req",  bus.rd_req, 1'b0);
      check("rst.rd_addr", bus.rd_addr, 14'h2000);
      check("rst.cycle",   cycle_cnt, 0);
      check("rst.evt",     evt_cnt, 0);

      //         name       num  mrk junk mask                    dly cycle err faddr     fdata          pass tmo hs
      vecs[0] = '{"match4",   4, 50,  0, 64'h0,                    0,  50,  0, 14'h0,    32'h0,          1, 0,  4};
      vecs[1] = '{"twoerr",   4, 50,  0, 64'hC,                    1,  50,  2, 14'h2002, 32'h0000_DEAD,  0, 0,  4};
      vecs[2] = '{"junkwr",   3, 80, 40, 64'h0,                    0,  80,  0, 14'h0,    32'h0,          1, 0,  3};
      vecs[3] = '{"tmo",      2,  0,  0, 64'h0,                    0, 299,  0, 14'h0,    32'h0,          0, 1,  2};
      vecs[4] = '{"zero",     0, 20,  0, 64'h0,                    0,  20,  0, 14'h0,    32'h0,          1, 0,  0};
      vecs[5] = '{"clamp",  100, 30,  0, 64'h8000_0000_0000_0000,  0,  30,  1, 14'h203F, 32'hEFFF_C0C0,  0, 0, 64};
      vecs[6] = '{"slow1",    1, 40,  0, 64'h1,                    5,  40,  1, 14'h2000, 32'hEFFF_FFFF,  0, 0,  1};

      foreach (vecs[v]) begin
         int   last;
         logic addr_ok;
         start_run(vecs[v].num, vecs[v].delay, vecs[v].mask);
         last = (vecs[v].marker > vecs[v].junk) ? vecs[v].marker : vecs[v].junk;
         for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == vecs[v].junk)        dm_write(14'h3fff, 32'h0000_1234);
            else if (c == vecs[v].marker) dm_write(14'h3fff, 32'hFFFF_FFFF);
            else                          bus.dm_we = 1'b0;
         end
         @(negedge clk);
         bus.dm_we = 1'b0;
         wait_done(TIMEOUT + 1000);
         check({vecs[v].name, ".pass"},    pass,           vecs[v].exp_pass);
         check({vecs[v].name, ".timeout"}, timeout,        vecs[v].exp_tmo);
         check({vecs[v].name, ".err_cnt"}, err_cnt,        vecs[v].exp_err);
         check({vecs[v].name, ".faddr"},   first_err_addr, vecs[v].exp_faddr);
         check({vecs[v].name, ".fdata"},   first_err_data, vecs[v].exp_fdata);
         check({vecs[v].name, ".cycle"},   cycle_cnt,      vecs[v].exp_cycle);
         check({vecs[v].name, ".hs_cnt"},  hs_cnt,         vecs[v].exp_hs);
         addr_ok = 1'b1;
         for (int k = 0; k < hs_cnt && k < MAX_WORDS; k++)
            if (hs_addr[k] !== 14'h2000 + 14'(k)) addr_ok = 1'b0;
         check({vecs[v].name, ".hs_addr"}, addr_ok, 1'b1);
         // Later markers and events must not disturb the result.
         dm_write(14'h3fff, 32'hFFFF_FFFF);
         evt_inc = 2'b11;
         repeat (3) @(negedge clk);
         bus.dm_we = 1'b0;
         evt_inc   = '0;
         check({vecs[v].name, ".sticky_done"},  done,      1'b1);
         check({vecs[v].name, ".sticky_cycle"}, cycle_cnt, vecs[v].exp_cycle);
         check({vecs[v].name, ".sticky_evt"},   evt_cnt,   0);
      end

      // Event counters: 10 pulses on ch0, 7 on ch1, more on both after the trigger.
      start_run(1, 0, 64'h0);
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         evt_inc[0] = (c >= 5 && c < 15) || (c >= 60 && c < 70);
         evt_inc[1] = (c >= 20 && c < 27) || (c >= 60 && c < 70);
         if (c == 50) dm_write(14'h3fff, 32'hFFFF_FFFF);
         else         bus.dm_we = 1'b0;
      end
      @(negedge clk);
      evt_inc = '0;
      wait_done(200);
      check("evt.ch0",   evt_cnt[63:0],   10);
      check("evt.ch1",   evt_cnt[127:64], 7);
      check("evt.cycle", cycle_cnt,       50);
      check("evt.pass",  pass,            1'b1);

      // Delayed ack, address stability, then reset during CHECK_WAIT.
      begin
         int   n;
         logic stable;
         start_run(3, 5, 64'h0);
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 20) dm_write(14'h3fff, 32'hFFFF_FFFF);
         end
         @(negedge clk);
         bus.dm_we = 1'b0;
         n = 0;
         while (!bus.rd_req && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("wait.req_seen", bus.rd_req, 1'b1);
         stable = 1'b1;
         n = 0;
         while (!bus.rd_ack && n < 20) begin
            if (bus.rd_addr !== 14'h2000 || bus.gold_addr !== 6'd0 || bus.rd_req !== 1'b1)
               stable = 1'b0;
            @(negedge clk);
            n++;
         end
         check("wait.stable", stable, 1'b1);
         check("wait.len",    n,      6);
         repeat (2) @(negedge clk);
         check("wait.addr2",  bus.rd_addr, 14'h2001);
         check("wait.req2",   bus.rd_req,  1'b1);
         @(posedge clk);
         #2 rst = 1'b0;
         #1;
         check("mid_rst.rd_req",  bus.rd_req,     1'b0);
         check("mid_rst.rd_addr", bus.rd_addr,    14'h2000);
         check("mid_rst.gaddr",   bus.gold_addr,  0);
         check("mid_rst.done",    done,           1'b0);
         check("mid_rst.pass",    pass,           1'b0);
         check("mid_rst.err",     err_cnt,        0);
         check("mid_rst.faddr",   first_err_addr, 0);
         check("mid_rst.cycle",   cycle_cnt,      0);
         @(negedge clk);
         rst = 1'b1;
         repeat (10) @(negedge clk);
         check("post_rst.cycle",  cycle_cnt,  10);
         check("post_rst.rd_req", bus.rd_req, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
